// File: rtl/counter_pkg.sv
// Shared constants and types for the counter timebase.
`timescale 1ns/1ps
package counter_pkg;

    localparam int COUNTER_DEFAULT_WIDTH = 16;

    typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter_if.sv
// Terminal-value input and count/tick outputs of the counter timebase.
// master drives the terminal value; slave is the counter itself.
`timescale 1ns/1ps
interface counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] times;
    logic [WIDTH-1:0] cnt;
    logic             c;

    modport master (
        output times,
        input  cnt,
        input  c
    );

    modport slave (
        input  times,
        output cnt,
        output c
    );

endinterface

// File: rtl/counter.sv
// Free-running modulo counter: period times+1, one-cycle terminal pulse c.
// Optional clock enable input `ce` when COUNTER_CE_EN is defined.
`timescale 1ns/1ps
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
`ifdef COUNTER_CE_EN
    input  logic      ce,
`endif
    counter_if.slave  bus
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_term;
    logic             w_adv;

    // >= rather than == so a terminal value lowered below the count wraps at once.
    assign w_term    = (r_cnt >= bus.times);
    assign w_cnt_nxt = w_term ? '0 : r_cnt + 1'b1;

`ifdef COUNTER_CE_EN
    assign w_adv = ce;
    assign bus.c = ce & w_term;
`else
    assign w_adv = 1'b1;
    assign bus.c = w_term;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_adv) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.cnt = r_cnt;

endmodule

// File: tb/tb_counter.sv
// Bench for the counter timebase: directed scenarios plus a randomized run
// against a behavioural model of the count.
`timescale 1ns/1ps
module tb_counter;
    import counter_pkg::*;

    localparam int W = COUNTER_DEFAULT_WIDTH;

    logic clk;
    logic reset;
    logic ce_v;

    int n_checks;
    int n_errors;

    int unsigned m_cnt;
    int unsigned m_times;

    counter_if #(.WIDTH(W)) bus ();

    counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef COUNTER_CE_EN
        .ce    (ce_v),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_c();
        return ce_v && (m_cnt >= m_times);
    endfunction

    task automatic set_times(input int unsigned t);
        m_times   = t;
        bus.times = count_t'(t);
    endtask

    // Advance one clock; model follows the modulo rule using pre-edge inputs.
    task automatic tick();
        int unsigned nxt;
        nxt = m_cnt;
        if (reset && ce_v) nxt = (m_cnt >= m_times) ? 0 : m_cnt + 1;
        if (!reset) nxt = 0;
        @(posedge clk);
        #1;
        m_cnt = nxt;
    endtask

    task automatic restart(input int unsigned t);
        reset = 1'b0;
        ce_v  = 1'b1;
        m_cnt = 0;
        set_times(t);
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        int unsigned ec;
        logic        exp_cc;
        reset = 1'b0;
        ce_v  = 1'b1;
        m_cnt = 0;
        set_times(5);
        repeat (3) begin
            tick();
            n_checks++;
            if (bus.cnt !== count_t'(0) || bus.c !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_hold: cnt=%0d c=%0b required cnt=0 c=0", bus.cnt, bus.c);
            end
        end
        reset = 1'b1;
        #1;
        for (int k = 0; k < 14; k++) begin
            ec     = k % 6;
            exp_cc = (ec == 5);
            n_checks++;
            if (bus.cnt !== count_t'(ec) || bus.c !== exp_cc) begin
                n_errors++;
                $display("FAIL reset_release k=%0d: cnt=%0d c=%0b required cnt=%0d c=%0b",
                         k, bus.cnt, bus.c, ec, exp_cc);
            end
            tick();
        end
    endtask

    task automatic test_times_zero();
        restart(0);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (bus.cnt !== count_t'(0) || bus.c !== 1'b1) begin
                n_errors++;
                $display("FAIL times_zero k=%0d: cnt=%0d c=%0b required cnt=0 c=1", k, bus.cnt, bus.c);
            end
            tick();
        end
    endtask

    task automatic test_full_range();
        int cycles;
        restart(32'hFFFF);
        cycles = 0;
        while (bus.c !== 1'b1 && cycles < 70000) begin
            tick();
            cycles++;
        end
        n_checks++;
        if (cycles != 65535 || bus.cnt !== count_t'(16'hFFFF)) begin
            n_errors++;
            $display("FAIL full_range_first_tick: cycles=%0d cnt=%h required cycles=65535 cnt=ffff",
                     cycles, bus.cnt);
        end
        tick();
        n_checks++;
        if (bus.cnt !== count_t'(0) || bus.c !== 1'b0) begin
            n_errors++;
            $display("FAIL full_range_wrap: cnt=%h c=%0b required cnt=0 c=0", bus.cnt, bus.c);
        end
    endtask

    task automatic test_times_change();
        int guard;
        int unsigned ec;
        restart(10);
        guard = 0;
        while (m_cnt != 7 && guard < 20) begin
            tick();
            guard++;
        end
        set_times(3);
        #1;
        n_checks++;
        if (bus.cnt !== count_t'(7) || bus.c !== 1'b1) begin
            n_errors++;
            $display("FAIL times_lowered: cnt=%0d c=%0b required cnt=7 c=1", bus.cnt, bus.c);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            ec = k % 4;
            n_checks++;
            if (bus.cnt !== count_t'(ec) || bus.c !== (ec == 3)) begin
                n_errors++;
                $display("FAIL times_new_period k=%0d: cnt=%0d c=%0b required cnt=%0d c=%0b",
                         k, bus.cnt, bus.c, ec, (ec == 3));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        restart(9);
        repeat (4) tick();
        n_checks++;
        if (bus.cnt !== count_t'(4)) begin
            n_errors++;
            $display("FAIL reset_mid_pre: cnt=%0d required 4", bus.cnt);
        end
        #2;
        reset = 1'b0;
        m_cnt = 0;
        #1;
        n_checks++;
        if (bus.cnt !== count_t'(0) || bus.c !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_async: cnt=%0d c=%0b required cnt=0 c=0", bus.cnt, bus.c);
        end
        repeat (2) begin
            tick();
            n_checks++;
            if (bus.cnt !== count_t'(0) || bus.c !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid_hold: cnt=%0d c=%0b required cnt=0 c=0", bus.cnt, bus.c);
            end
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (bus.cnt !== count_t'(1)) begin
            n_errors++;
            $display("FAIL reset_mid_restart: cnt=%0d required 1", bus.cnt);
        end
    endtask

`ifdef COUNTER_CE_EN
    task automatic test_ce();
        logic        ce_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int unsigned exp_cnt[6] = '{1, 1, 2, 0, 0, 1};
        logic        exp_cc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        restart(2);
        for (int k = 0; k < 6; k++) begin
            ce_v = ce_pat[k];
            #1;
            n_checks++;
            if (bus.c !== exp_cc[k]) begin
                n_errors++;
                $display("FAIL ce_pulse k=%0d: c=%0b required %0b", k, bus.c, exp_cc[k]);
            end
            tick();
            n_checks++;
            if (bus.cnt !== count_t'(exp_cnt[k])) begin
                n_errors++;
                $display("FAIL ce_count k=%0d: cnt=%0d required %0d", k, bus.cnt, exp_cnt[k]);
            end
        end
        ce_v = 1'b1;
    endtask
`endif

    task automatic test_random();
        restart($urandom_range(1, 12));
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) set_times($urandom_range(0, 12));
`ifdef COUNTER_CE_EN
            ce_v = ($urandom_range(0, 3) != 0);
`endif
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b0;
                m_cnt = 0;
            end else begin
                reset = 1'b1;
            end
            #1;
            n_checks++;
            if (bus.cnt !== count_t'(m_cnt) || bus.c !== model_c()) begin
                n_errors++;
                $display("FAIL random k=%0d times=%0d: cnt=%0d c=%0b required cnt=%0d c=%0b",
                         k, m_times, bus.cnt, bus.c, m_cnt, model_c());
            end
            tick();
        end
        reset = 1'b1;
        ce_v  = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        ce_v      = 1'b1;
        m_cnt     = 0;
        m_times   = 0;
        bus.times = '0;
        #2;
        test_reset();
        test_times_zero();
        test_times_change();
        test_reset_mid();
`ifdef COUNTER_CE_EN
        test_ce();
`endif
        test_random();
        test_full_range();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
